// File: rtl/input_conditioner.sv
// Multi-channel input front end: synchroniser, tick-based debounce, edge strobes and press strobe.
// Define INPUT_COND_REPEAT_EN to build the per-channel hold-to-repeat logic.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_DELAY   = 1000,
  parameter int REPEAT_PERIOD  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pressed
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] TICK_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_MAX = CW'(PULSE_CNT_MAX);

  if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("input_conditioner: parameter out of range");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [SW-1:0]    tick_cnt;
  logic             tick;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] level_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + SW'(1);
  end

  // A low sample clears immediately; counting up only happens on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      level   <= '0;
      level_d <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < WIDTH; i++) begin
        if (!s[i]) begin
          cnt[i]   <= '0;
          level[i] <= 1'b0;
        end else if (tick && cnt[i] < PULSE_MAX) begin
          cnt[i] <= cnt[i] + CW'(1);
          if (cnt[i] == PULSE_MAX - CW'(1)) level[i] <= 1'b1;
        end
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

`ifdef INPUT_COND_REPEAT_EN
  // state     | meaning
  // ST_ARM    | level held, counting ticks towards the first repeat
  // ST_REPEAT | first repeat done, counting ticks between later repeats
  typedef enum logic {ST_ARM, ST_REPEAT} rep_state_t;

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  rep_state_t       state [WIDTH];
  logic [RW-1:0]    rcnt  [WIDTH];
  logic [WIDTH-1:0] rep_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= ST_ARM;
        rcnt[i]  <= '0;
      end
      rep_pulse <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!level[i]) begin
          state[i] <= ST_ARM;
          rcnt[i]  <= '0;
        end else if (tick) begin
          case (state[i])
            ST_ARM: begin
              if (rcnt[i] == DELAY_LAST) begin
                rep_pulse[i] <= 1'b1;
                state[i]     <= ST_REPEAT;
                rcnt[i]      <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + RW'(1);
              end
            end
            ST_REPEAT: begin
              if (rcnt[i] == PERIOD_LAST) begin
                rep_pulse[i] <= 1'b1;
                rcnt[i]      <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + RW'(1);
              end
            end
            default: begin
              state[i] <= ST_ARM;
              rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign pressed = rise | rep_pulse;
`else
  assign pressed = rise;
`endif

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel front end for asynchronous board inputs such as buttons and switches. It replaces the separate synchronizer and button debounce stages with one block. Per channel it provides a synchronised, debounced level, single-cycle rise and fall strobes, and a `pressed` strobe with optional hold-to-repeat. It sits between the board pins and the CPU and MMIO logic, in the `clk` domain.

## Interface
- `WIDTH`, 4 — number of independent channels.
- `SYNC_STAGES`, 2 — flip-flops in each input synchroniser; must be ≥2.
- `SAMPLE_CNT_MAX`, 25000 — `clk` cycles per sample tick; must be ≥1.
- `PULSE_CNT_MAX`, 200 — consecutive high ticks required before `level` asserts; must be ≥1.
- `REPEAT_DELAY`, 1000 — ticks from `level` rise to the first repeat strobe; must be ≥1.
- `REPEAT_PERIOD`, 200 — ticks between later repeat strobes; must be ≥1.

Ports:
- `clk` input 1 — single clock domain.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `in` input WIDTH — raw asynchronous inputs, active-high.
- `level` output WIDTH — debounced level, registered.
- `rise` output WIDTH — one-cycle strobe on the first cycle `level` is 1.
- `fall` output WIDTH — one-cycle strobe on the first cycle `level` is 0 after being 1.
- `pressed` output WIDTH — press strobe, including repeats when enabled.

## Operation
- **Synchroniser:** `SYNC_STAGES`-deep flop chain per channel. Its output is `s[i]`.
- **Tick counter:** one counter shared by all channels. It runs freely from reset over 0..`SAMPLE_CNT_MAX`-1. `tick` is 1 in the cycle the count equals `SAMPLE_CNT_MAX`-1, then the count wraps to 0. With `SAMPLE_CNT_MAX`=1, `tick` is 1 every cycle.
- **Debounce counter** `cnt[i]`, width clog2(`PULSE_CNT_MAX`+1):
  - `s[i]`=0 in any cycle: `cnt`←0 and `level[i]`←0 at that edge. Clearing does not wait for a tick.
  - `tick` with `s[i]`=1 and `cnt`<`PULSE_CNT_MAX`: `cnt`←`cnt`+1. If the new value equals `PULSE_CNT_MAX`, `level[i]`←1 at the same edge.
  - `cnt` saturates at `PULSE_CNT_MAX`.
- **Edge strobes:** `level_d` is `level` delayed by one cycle.
  - `rise` = `level` & ~`level_d`.
  - `fall` = ~`level` & `level_d`.
  - Each strobe lasts exactly one cycle per transition.
- **`pressed`:** equals `rise` OR `rep_pulse`. `rep_pulse` is a registered one-cycle strobe; see Configuration.
- **Repeat FSM** (per channel), states ARM and REPEAT, with tick counter `rcnt`:
  - `level`=0: state←ARM, `rcnt`←0, no pulse.
  - ARM, on `tick` with `level`=1:
    - `rcnt`=`REPEAT_DELAY`-1: set `rep_pulse`, state←REPEAT, `rcnt`←0.
    - otherwise: `rcnt`++.
  - REPEAT, on `tick` with `level`=1:
    - `rcnt`=`REPEAT_PERIOD`-1: set `rep_pulse`, `rcnt`←0.
    - otherwise: `rcnt`++.
  - `rep_pulse` is high for the single cycle after the triggering tick edge.
- **Channel independence:** channels are fully independent. Any combination of simultaneous events across channels is legal.

## Timing
- **Reset values:** `rst_n` low asynchronously clears all synchronisers, counters, FSMs and outputs. `level`, `rise`, `fall` and `pressed` are 0.
- **After reset release:**
  - The tick counter restarts at 0.
  - An input already held high must be debounced again from 0.
  - No `rise` occurs at the release edge.
- **Reset during a press:** the press is lost. `fall` is not emitted.
- **Assert latency:** from a steady high at `in` to `level`=1 is `SYNC_STAGES` + (`PULSE_CNT_MAX`-1)·`SAMPLE_CNT_MAX` + 1 … `SYNC_STAGES` + `PULSE_CNT_MAX`·`SAMPLE_CNT_MAX` cycles. The spread depends on tick phase.
- **Deassert latency:** `SYNC_STAGES`+1 cycles from `in` low to `level`=0.
- **Overlap rule:** `rise` and `rep_pulse` never coincide, because the first repeat needs ≥1 tick after `level` rises.
- **Glitches:** a low glitch lasting ≥1 synchronised cycle restarts the debounce.

## Configuration
- **`INPUT_COND_REPEAT_EN` defined:** the repeat FSM, `rcnt` and `rep_pulse` are built. `pressed` = `rise` | `rep_pulse`.
- **`INPUT_COND_REPEAT_EN` undefined:**
  - No repeat logic is synthesised.
  - `pressed` = `rise`.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Unless stated otherwise, all scenarios use `SAMPLE_CNT_MAX`=4, `PULSE_CNT_MAX`=3, `SYNC_STAGES`=2, `WIDTH`=4.

- **Reset with input high:** `rst_n`=0 with `in`=4'hF, release, hold high → all outputs 0 during reset. `level`=4'hF within 2+12 cycles of release. `rise` and `pressed` are one-cycle 4'hF.
- **Bounce:** `in[0]` toggles every 3 cycles for 40 cycles, then stays high → `level[0]` stays 0 while bouncing. Exactly one `rise[0]`, 11–14 cycles after the final high.
- **Release:** with `level[1]`=1, drive `in[1]`=0 → `level[1]`=0 exactly 3 cycles later. `fall[1]` is a single cycle.
- **Mixed channels:** `in[2]` rises while `in[3]` falls in the same cycle → `rise[2]` and `fall[3]` occur independently with the latencies above. Other channels are unaffected.
- **Repeat, macro defined:** `REPEAT_DELAY`=5, `REPEAT_PERIOD`=2, hold `in[0]` → `pressed[0]` at `rise`, again 20 cycles later, then every 8 cycles. Releasing `in[0]` stops repeats.
- **Repeat, macro undefined:** same stimulus → `pressed[0]` pulses exactly once.
